uart_rx_bcd_display: RTL and testbench

Parametrised serial-to-display receiver. It oversamples an asynchronous UART line and frames LSB-first bytes of configurable width. Each valid byte is converted to decimal with a sequential shift-and-add-3 (double-dabble) engine and drives DIGITS seven-segment outputs. It replaces the fixed 8-bit, 3-digit receiver/separator/display chain and adds frame checking, optional parity and a conversion handshake.

---
 rtl/uart_rx_bcd_display.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_bcd_display.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_bcd_display.sv
// UART receiver that frames LSB-first words, converts them to decimal via double-dabble
// and drives DIGITS active-low seven-segment outputs. Define UART_PARITY_EN for even parity.
module uart_rx_bcd_display #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int DIGITS       = 3
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iRx,
  output logic [7*DIGITS-1:0]   oS,
  output logic                  oValid,
  output logic                  oBusy,
  output logic                  oFrameErr,
  output logic                  oParityErr
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam int DD_W  = BCD_W + DATA_BITS;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP, CONV
  } state_t;

  state_t state_reg, state_next;
  logic rx_meta, rx_s;
  logic armed_reg, armed_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next, bin_reg, bin_next;
  logic [BCD_W-1:0] bcd_reg, bcd_next, bcd_adj;
  logic [DD_W-1:0] dd_shift;
  logic [7*DIGITS-1:0] seg_dec, seg_next;
  logic valid_next, busy_next, frame_err_next;
  logic in_bit, sample, last_bit;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: seg_of = 7'h40;
      4'd1: seg_of = 7'h79;
      4'd2: seg_of = 7'h24;
      4'd3: seg_of = 7'h30;
      4'd4: seg_of = 7'h19;
      4'd5: seg_of = 7'h12;
      4'd6: seg_of = 7'h02;
      4'd7: seg_of = 7'h78;
      4'd8: seg_of = 7'h00;
      4'd9: seg_of = 7'h10;
      default: seg_of = 7'h7F;
    endcase
  endfunction

  // One double-dabble iteration: add 3 to digits >= 5, then shift binary MSB into BCD.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] d;
      assign d = bcd_reg[4*gi +: 4];
      assign bcd_adj[4*gi +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
      assign seg_dec[7*gi +: 7] = seg_of(dd_shift[DATA_BITS + 4*gi +: 4]);
    end
  endgenerate
  assign dd_shift = {bcd_adj, bin_reg} << 1;

`ifdef UART_PARITY_EN
  logic parity_err_next;
  assign in_bit = (state_reg == DATA) || (state_reg == PARITY) || (state_reg == STOP);
`else
  assign in_bit = (state_reg == DATA) || (state_reg == STOP);
  assign oParityErr = 1'b0;
`endif
  assign sample   = (state_reg == START) ? (cnt_reg == HALF_LAST) : (in_bit && cnt_reg == FULL_LAST);
  assign last_bit = (bit_cnt_reg == BITS_LAST);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rx_meta     <= 1'b0;
      rx_s        <= 1'b0;
      armed_reg   <= 1'b0;
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      bin_reg     <= '0;
      bcd_reg     <= '0;
      oS          <= {DIGITS{7'h40}};
      oValid      <= 1'b0;
      oBusy       <= 1'b0;
      oFrameErr   <= 1'b0;
`ifdef UART_PARITY_EN
      oParityErr  <= 1'b0;
`endif
    end else begin
      rx_meta     <= iRx;
      rx_s        <= rx_meta;
      armed_reg   <= armed_next;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      bin_reg     <= bin_next;
      bcd_reg     <= bcd_next;
      oS          <= seg_next;
      oValid      <= valid_next;
      oBusy       <= busy_next;
      oFrameErr   <= frame_err_next;
`ifdef UART_PARITY_EN
      oParityErr  <= parity_err_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (armed_reg && !rx_s) state_next = START;
      START:  if (sample) state_next = rx_s ? IDLE : DATA;
      DATA:   if (sample && last_bit)
`ifdef UART_PARITY_EN
                state_next = PARITY;
      PARITY: if (sample) state_next = (^shift_reg ^ rx_s) ? IDLE : STOP;
`else
                state_next = STOP;
`endif
      STOP:   if (sample) state_next = rx_s ? CONV : IDLE;
      CONV:   if (last_bit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    // A start bit needs the line seen high since the previous sample point.
    armed_next     = rx_s ? 1'b1 : (sample ? 1'b0 : armed_reg);
    cnt_next       = (state_reg == IDLE || state_reg == CONV || sample) ? '0 : cnt_reg + CNT_W'(1);
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    bin_next       = bin_reg;
    bcd_next       = bcd_reg;
    seg_next       = oS;
    valid_next     = 1'b0;
    busy_next      = (state_next != IDLE);
    frame_err_next = 1'b0;
`ifdef UART_PARITY_EN
    parity_err_next = 1'b0;
`endif
    case (state_reg)
      IDLE: bit_cnt_next = '0;
      DATA: if (sample) begin
        shift_next   = {rx_s, shift_reg[DATA_BITS-1:1]};
        bit_cnt_next = last_bit ? '0 : bit_cnt_reg + BIT_W'(1);
      end
`ifdef UART_PARITY_EN
      PARITY: if (sample && (^shift_reg ^ rx_s)) parity_err_next = 1'b1;
`endif
      STOP: if (sample) begin
        if (rx_s) begin
          bin_next = shift_reg;
          bcd_next = '0;
        end else begin
          frame_err_next = 1'b1;
        end
      end
      CONV: begin
        {bcd_next, bin_next} = dd_shift;
        bit_cnt_next = last_bit ? '0 : bit_cnt_reg + BIT_W'(1);
        if (last_bit) begin
          seg_next   = seg_dec;
          valid_next = 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_uart_rx_bcd_display.sv
// Randomised self-checking bench for uart_rx_bcd_display; the expected display is
// derived from decimal arithmetic on the last accepted byte.
module tb_uart_rx_bcd_display;
  localparam int CLKS = 16;
  localparam int DB   = 8;
  localparam int DIG  = 3;
`ifdef UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int LATENCY = 2 + CLKS / 2 + (DB + 1 + PAR) * CLKS + DB + 1;

  typedef logic bitq_t[$];

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic [7*DIG-1:0] seg;
  logic valid, busy, frame_err, parity_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int valid_cnt = 0, ferr_cnt = 0, perr_cnt = 0, busy_rise = 0, valid_cyc = 0;
  logic busy_d = 1'b0;
  logic [31:0] cap_q[$];
  int disp_val = 0;

  uart_rx_bcd_display #(.CLKS_PER_BIT(CLKS), .DATA_BITS(DB), .DIGITS(DIG)) dut (
    .iClk(clk), .iRst(rst), .iRx(rx), .oS(seg), .oValid(valid),
    .oBusy(busy), .oFrameErr(frame_err), .oParityErr(parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      valid_cyc = cyc;
      cap_q.push_back(32'(seg));
    end
    if (frame_err) ferr_cnt++;
    if (parity_err) perr_cnt++;
    if (busy && !busy_d) busy_rise++;
    busy_d = busy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_code(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [31:0] seg_model(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIG; i++) begin
      r = r | (32'(seg_code(x % 10)) << (7 * i));
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bitq_t make_frame(input int data, input logic stop_bit);
    bitq_t q;
    int ones;
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < DB; i++) begin
      q.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (PAR == 1) q.push_back(ones[0]);
    q.push_back(stop_bit);
    return q;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered and left one time unit after a rising edge.
  task automatic send_bits(input bitq_t q, output int t0);
    t0 = cyc;
    foreach (q[i]) begin
      rx = q[i];
      idle(CLKS);
    end
    rx = 1'b1;
  endtask

  initial begin
    int t0, v0, f0, p0, b0, v;
    logic bad;
    bitq_t q;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_seg", 32'(seg), seg_model(0));
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ferr", 32'(frame_err), 32'd0);
    check("reset_perr", 32'(parity_err), 32'd0);
    rst = 1'b0;
    idle(5);

    // 0xFF: value and latency
    v0 = valid_cnt;
    send_bits(make_frame(8'hFF, 1'b1), t0);
    idle(12);
    disp_val = 255;
    $display("frame data=ff stop=1 seg=%h", seg);
    check("ff_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("ff_latency", 32'(valid_cyc - t0), 32'(LATENCY));
    check("ff_seg", 32'(seg), seg_model(disp_val));
    check("ff_busy", 32'(busy), 32'd0);

    // 0x7B then 0x00 back-to-back
    v0 = valid_cnt;
    cap_q.delete();
    send_bits(make_frame(8'h7B, 1'b1), t0);
    send_bits(make_frame(8'h00, 1'b1), t0);
    idle(12);
    disp_val = 0;
    $display("frame data=7b,00 stop=1 seg=%h", seg);
    check("b2b_valid_count", 32'(valid_cnt - v0), 32'd2);
    check("b2b_first", (cap_q.size() > 0) ? cap_q[0] : 32'hFFFF_FFFF, seg_model(123));
    check("b2b_second", (cap_q.size() > 1) ? cap_q[1] : 32'hFFFF_FFFF, seg_model(0));

    // False start: 4 low cycles
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_rise;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    $display("false start seg=%h busy=%0d", seg, busy);
    check("fs_busy_rise", 32'(busy_rise - b0), 32'd1);
    check("fs_busy", 32'(busy), 32'd0);
    check("fs_valid", 32'(valid_cnt - v0), 32'd0);
    check("fs_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("fs_seg", 32'(seg), seg_model(disp_val));

    // Framing error keeps the display
    v0 = valid_cnt; f0 = ferr_cnt;
    send_bits(make_frame(8'h2A, 1'b0), t0);
    idle(2 * CLKS);
    $display("frame data=2a stop=0 seg=%h", seg);
    check("ferr_count", 32'(ferr_cnt - f0), 32'd1);
    check("ferr_valid", 32'(valid_cnt - v0), 32'd0);
    check("ferr_seg", 32'(seg), seg_model(disp_val));

    send_bits(make_frame(150, 1'b1), t0);
    idle(12);
    disp_val = 150;
    check("pre_rst_seg", 32'(seg), seg_model(disp_val));

    // Reset in the middle of a 0x55 frame
    v0 = valid_cnt;
    q = make_frame(8'h55, 1'b1);
    for (int i = 0; i < 5; i++) begin
      rx = q[i];
      idle(CLKS);
    end
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    $display("reset mid-frame seg=%h busy=%0d", seg, busy);
    check("mid_rst_seg", 32'(seg), seg_model(0));
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_ferr", 32'(frame_err), 32'd0);
    rx = 1'b1;
    idle(2);
    rst = 1'b0;
    disp_val = 0;
    idle(6 * CLKS);
    check("post_rst_valid", 32'(valid_cnt - v0), 32'd0);
    check("post_rst_seg", 32'(seg), seg_model(disp_val));

`ifdef UART_PARITY_EN
    p0 = perr_cnt; v0 = valid_cnt;
    q = make_frame(8'h03, 1'b1);
    q[DB + 1] = 1'b1;
    send_bits(q, t0);
    idle(2 * CLKS);
    $display("frame data=03 parity=1 seg=%h", seg);
    check("par_bad_count", 32'(perr_cnt - p0), 32'd1);
    check("par_bad_valid", 32'(valid_cnt - v0), 32'd0);
    check("par_bad_seg", 32'(seg), seg_model(disp_val));
    send_bits(make_frame(8'h03, 1'b1), t0);
    idle(12);
    disp_val = 3;
    $display("frame data=03 parity=0 seg=%h", seg);
    check("par_good_count", 32'(perr_cnt - p0), 32'd1);
    check("par_good_seg", 32'(seg), seg_model(disp_val));
`else
    p0 = perr_cnt;
`endif

    // Randomised frames, some with a bad stop bit
    for (int n = 0; n < 12; n++) begin
      v   = int'($urandom_range(0, (1 << DB) - 1));
      bad = ($urandom_range(0, 4) == 0);
      v0 = valid_cnt; f0 = ferr_cnt;
      send_bits(make_frame(v, !bad), t0);
      idle(bad ? 2 * CLKS : 12);
      if (!bad) disp_val = v;
      $display("frame data=%0d stop=%0d seg=%h", v, !bad, seg);
      check("rnd_valid", 32'(valid_cnt - v0), bad ? 32'd0 : 32'd1);
      check("rnd_ferr", 32'(ferr_cnt - f0), bad ? 32'd1 : 32'd0);
      check("rnd_seg", 32'(seg), seg_model(disp_val));
      check("rnd_busy", 32'(busy), 32'd0);
    end
    check("no_stray_perr", 32'(perr_cnt - p0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
